// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and helpers for the OTTER fetch-stage PC sequencer.
//   pc_src_t   - encoding of the PC_SOURCE select (6/7 are illegal)
//   pc_state_t - sequencer state (BOOT, RUN, PENDING)
//   is_trap_src() - true for selects that may overwrite a captured redirect
package pc_seq_pkg;

  typedef enum logic [2:0] {
    SRC_PLUS4  = 3'd0,
    SRC_JALR   = 3'd1,
    SRC_BRANCH = 3'd2,
    SRC_JAL    = 3'd3,
    SRC_MTVEC  = 3'd4,
    SRC_MEPC   = 3'd5
  } pc_src_t;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PENDING = 2'd2
  } pc_state_t;

  // Trap entry and trap return are the only selects allowed to replace a
  // redirect that is already waiting for fetch.
  function automatic logic is_trap_src(input logic [2:0] sel);
    return (sel == SRC_MTVEC) || (sel == SRC_MEPC);
  endfunction

endpackage

// File: rtl/pc_target_sel.sv
// pc_target_sel: combinational next-PC target selection and classification.
// Ports:
//   sel          - PC source select (pc_src_t encoding)
//   pc_plus_four - sequential successor of the current PC
//   jalr, branch, jal, mtvec, mepc - candidate targets
//   target       - selected target (JALR with bit0 cleared)
//   misaligned   - control-flow target (JALR/BRANCH/JAL) violates ALIGN_BITS
//   illegal      - select value 6 or 7
import pc_seq_pkg::*;

module pc_target_sel #(
  parameter int XLEN       = 32,
  parameter int ALIGN_BITS = 2
) (
  input  logic [2:0]      sel,
  input  logic [XLEN-1:0] pc_plus_four,
  input  logic [XLEN-1:0] jalr,
  input  logic [XLEN-1:0] branch,
  input  logic [XLEN-1:0] jal,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] target,
  output logic            misaligned,
  output logic            illegal
);

  // Low address bits that must be zero for a legal control-flow target.
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1'b1) << ALIGN_BITS) - XLEN'(1'b1);

  logic checked_s;

  // Pick the target and note whether it is subject to the alignment rule;
  // trap vectors are trusted and never checked.
  always_comb begin
    target    = pc_plus_four;
    checked_s = 1'b0;
    illegal   = 1'b0;
    case (sel)
      SRC_PLUS4:  target = pc_plus_four;
      SRC_JALR: begin
        target    = jalr & ~XLEN'(1'b1);
        checked_s = 1'b1;
      end
      SRC_BRANCH: begin
        target    = branch;
        checked_s = 1'b1;
      end
      SRC_JAL: begin
        target    = jal;
        checked_s = 1'b1;
      end
      SRC_MTVEC:  target = mtvec;
      SRC_MEPC:   target = mepc;
      default:    illegal = 1'b1;
    endcase
  end

  assign misaligned = checked_s && ((target & ALIGN_MASK) != {XLEN{1'b0}});

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: OTTER fetch-stage PC register with next-PC selection.
// Holds the PC, captures redirects arriving while fetch is stalled and
// replays them once fetch is ready, and reports misaligned/illegal updates.
// Ports:
//   CLK, RST          - clock and synchronous active-high reset
//   PC_WRITE          - controller requests a PC update
//   PC_SOURCE         - target select (pc_src_t)
//   JALR..MEPC        - candidate targets
//   FETCH_READY       - fetch accepts a new PC this cycle
//   PC, PC_PLUS_FOUR  - current PC and its sequential successor
//   PC_VALID          - PC is architecturally current
//   REDIRECT_PENDING  - a captured redirect awaits FETCH_READY
//   MISALIGN(_ADDR)   - rejected misaligned target pulse and its address
//   ILLEGAL_SEL       - PC_WRITE with an illegal select
//   REDIRECT_COUNT    - saturating count of applied non-PLUS4 updates
import pc_seq_pkg::*;

module pc_sequencer #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = {XLEN{1'b0}},
  parameter int              ALIGN_BITS = 2,
  parameter int              CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PC_WRITE,
  input  logic [2:0]       PC_SOURCE,
  input  logic [XLEN-1:0]  JALR,
  input  logic [XLEN-1:0]  BRANCH,
  input  logic [XLEN-1:0]  JAL,
  input  logic [XLEN-1:0]  MTVEC,
  input  logic [XLEN-1:0]  MEPC,
  input  logic             FETCH_READY,
  output logic [XLEN-1:0]  PC,
  output logic [XLEN-1:0]  PC_PLUS_FOUR,
  output logic             PC_VALID,
  output logic             REDIRECT_PENDING,
  output logic             MISALIGN,
  output logic [XLEN-1:0]  MISALIGN_ADDR,
  output logic             ILLEGAL_SEL,
  output logic [CNT_W-1:0] REDIRECT_COUNT
);

  pc_state_t        state_r;
  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  pending_r;
  logic             valid_r;
  logic             redirect_pending_r;
  logic             misalign_r;
  logic [XLEN-1:0]  misalign_addr_r;
  logic             illegal_r;
  logic [CNT_W-1:0] count_r;

  logic [XLEN-1:0]  pc_plus_four_s;
  logic [XLEN-1:0]  target_s;
  logic             misaligned_s;
  logic             illegal_s;

  // Wraps silently at 2^XLEN.
  assign pc_plus_four_s = pc_r + XLEN'(3'd4);

  // Saturating increment; the debug counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end else begin
      return c + CNT_W'(1'b1);
    end
  endfunction

  pc_target_sel #(
    .XLEN       (XLEN),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_target_sel (
    .sel          (PC_SOURCE),
    .pc_plus_four (pc_plus_four_s),
    .jalr         (JALR),
    .branch       (BRANCH),
    .jal          (JAL),
    .mtvec        (MTVEC),
    .mepc         (MEPC),
    .target       (target_s),
    .misaligned   (misaligned_s),
    .illegal      (illegal_s)
  );

  // Sequencer state machine: PC, captured redirect, pulses and counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r            <= ST_BOOT;
      pc_r               <= RESET_VEC;
      pending_r          <= {XLEN{1'b0}};
      valid_r            <= 1'b0;
      redirect_pending_r <= 1'b0;
      misalign_r         <= 1'b0;
      misalign_addr_r    <= {XLEN{1'b0}};
      illegal_r          <= 1'b0;
      count_r            <= {CNT_W{1'b0}};
    end else begin
      misalign_r <= 1'b0;
      illegal_r  <= 1'b0;
      case (state_r)
        // One dead cycle after reset; PC_WRITE is not honoured yet.
        ST_BOOT: begin
          state_r <= ST_RUN;
          valid_r <= 1'b1;
        end
        ST_RUN: begin
          if (!PC_WRITE) begin
            pc_r <= pc_r;
          end else if (illegal_s) begin
            illegal_r <= 1'b1;
          end else if (misaligned_s) begin
            misalign_r      <= 1'b1;
            misalign_addr_r <= target_s;
          end else if (FETCH_READY) begin
            pc_r <= target_s;
            if (PC_SOURCE != SRC_PLUS4) begin
              count_r <= sat_inc(count_r);
            end else begin
              count_r <= count_r;
            end
          end else if (PC_SOURCE != SRC_PLUS4) begin
            // Fetch is stalled: remember the redirect and replay it later.
            pending_r          <= target_s;
            state_r            <= ST_PENDING;
            valid_r            <= 1'b0;
            redirect_pending_r <= 1'b1;
          end else begin
            // Sequential step while stalled simply waits.
            pc_r <= pc_r;
          end
        end
        ST_PENDING: begin
          if (PC_WRITE && is_trap_src(PC_SOURCE)) begin
            // A trap supersedes the captured redirect.
            if (FETCH_READY) begin
              pc_r               <= target_s;
              count_r            <= sat_inc(count_r);
              state_r            <= ST_RUN;
              valid_r            <= 1'b1;
              redirect_pending_r <= 1'b0;
            end else begin
              pending_r <= target_s;
            end
          end else if (FETCH_READY) begin
            pc_r               <= pending_r;
            count_r            <= sat_inc(count_r);
            state_r            <= ST_RUN;
            valid_r            <= 1'b1;
            redirect_pending_r <= 1'b0;
          end else begin
            pending_r <= pending_r;
          end
        end
        default: begin
          state_r            <= ST_BOOT;
          valid_r            <= 1'b0;
          redirect_pending_r <= 1'b0;
        end
      endcase
    end
  end

  assign PC               = pc_r;
  assign PC_PLUS_FOUR     = pc_plus_four_s;
  assign PC_VALID         = valid_r;
  assign REDIRECT_PENDING = redirect_pending_r;
  assign MISALIGN         = misalign_r;
  assign MISALIGN_ADDR    = misalign_addr_r;
  assign ILLEGAL_SEL      = illegal_r;
  assign REDIRECT_COUNT   = count_r;

endmodule
